// File: rtl/wbu_link_peer.sv
// Far-end peer of the muxed debug-bus/console link: merges command and console
// characters into one tagged TX byte stream and splits received bytes into two FIFOs.

module wbu_link_peer_fifo #(
    parameter int unsigned LGFIFO = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_wr,
    input  logic [6:0] i_data,
    input  logic       i_busy,
    output logic       o_stb,
    output logic [6:0] o_data,
    output logic [7:0] o_drops
);
    localparam int unsigned DEPTH = 1 << LGFIFO;
    localparam int unsigned PW    = LGFIFO + 1;

    logic [6:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          empty_c, full_c, pop_c, wr_ok_c;

    // Extra pointer bit separates full from empty when the indices match
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[LGFIFO] != rd_ptr[LGFIFO])
                  && (wr_ptr[LGFIFO-1:0] == rd_ptr[LGFIFO-1:0]);
    assign pop_c   = !empty_c && !i_busy;
    assign wr_ok_c = i_wr && (!full_c || pop_c);

    assign o_stb  = !empty_c;
    assign o_data = mem[rd_ptr[LGFIFO-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_drops <= 8'd0;
        end else begin
            if (wr_ok_c)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)
                rd_ptr <= rd_ptr + PW'(1);
            if (i_wr && !wr_ok_c && (o_drops != 8'hFF))
                o_drops <= o_drops + 8'd1;
        end
    end

    // Storage needs no reset; pointers define validity
    always_ff @(posedge clk) begin
        if (wr_ok_c)
            mem[wr_ptr[LGFIFO-1:0]] <= i_data;
    end
endmodule

module wbu_link_peer #(
    parameter int unsigned LGFIFO          = 4,
    parameter bit          OPT_ROUND_ROBIN = 1'b1
) (
    input  logic       S_AXI_ACLK,
    input  logic       S_AXI_ARESETN,
    input  logic       i_cmd_stb,
    input  logic [6:0] i_cmd_data,
    output logic       o_cmd_busy,
    input  logic       i_console_stb,
    input  logic [6:0] i_console_data,
    output logic       o_console_busy,
    output logic       o_tx_stb,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_busy,
    input  logic       i_rx_stb,
    input  logic [7:0] i_rx_data,
    output logic       o_rsp_stb,
    output logic [6:0] o_rsp_data,
    input  logic       i_rsp_busy,
    output logic       o_con_stb,
    output logic [6:0] o_con_data,
    input  logic       i_con_busy,
    output logic [7:0] o_rsp_drops,
    output logic [7:0] o_con_drops
);
    logic tx_full;
    logic rr_cmd_next;
    logic cmd_pri_c, grant_cmd_c, grant_con_c;

    // Command priority on a tie: pointer in round-robin mode, fixed otherwise
    assign cmd_pri_c   = OPT_ROUND_ROBIN ? rr_cmd_next : 1'b1;
    assign grant_cmd_c = !tx_full && i_cmd_stb && (!i_console_stb || cmd_pri_c);
    assign grant_con_c = !tx_full && i_console_stb && (!i_cmd_stb || !cmd_pri_c);

    assign o_cmd_busy     = tx_full || (i_console_stb && !cmd_pri_c);
    assign o_console_busy = tx_full || (i_cmd_stb && cmd_pri_c);
    assign o_tx_stb       = tx_full;

    // Holding register: a drain cycle never loads, so peak rate is 1 byte per 2 clocks
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            tx_full     <= 1'b0;
            o_tx_data   <= 8'd0;
            rr_cmd_next <= 1'b1;
        end else if (tx_full) begin
            if (!i_tx_busy)
                tx_full <= 1'b0;
        end else if (grant_cmd_c) begin
            tx_full     <= 1'b1;
            o_tx_data   <= {1'b1, i_cmd_data};
            rr_cmd_next <= 1'b0;
        end else if (grant_con_c) begin
            tx_full     <= 1'b1;
            o_tx_data   <= {1'b0, i_console_data};
            rr_cmd_next <= 1'b1;
        end
    end

    wbu_link_peer_fifo #(.LGFIFO(LGFIFO)) u_rsp_fifo (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .i_wr    (i_rx_stb && i_rx_data[7]),
        .i_data  (i_rx_data[6:0]),
        .i_busy  (i_rsp_busy),
        .o_stb   (o_rsp_stb),
        .o_data  (o_rsp_data),
        .o_drops (o_rsp_drops)
    );

    wbu_link_peer_fifo #(.LGFIFO(LGFIFO)) u_con_fifo (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .i_wr    (i_rx_stb && !i_rx_data[7]),
        .i_data  (i_rx_data[6:0]),
        .i_busy  (i_con_busy),
        .o_stb   (o_con_stb),
        .o_data  (o_con_data),
        .o_drops (o_con_drops)
    );
endmodule

// File: tb/tb_wbu_link_peer.sv
// Directed bench for wbu_link_peer: a round-robin LGFIFO=2 instance and a
// fixed-priority default-depth instance driven from the same inputs.

module tb_wbu_link_peer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_stb, con_in_stb, tx_busy, rx_stb, rsp_busy, con_busy;
    logic [6:0] cmd_data, con_in_data;
    logic [7:0] rx_data;

    logic       cmd_busy, con_in_busy, tx_stb, rsp_stb, con_stb;
    logic [7:0] tx_data, rsp_drops, con_drops;
    logic [6:0] rsp_data, con_data;

    logic       cmd_busy0, con_in_busy0, tx_stb0, rsp_stb0, con_stb0;
    logic [7:0] tx_data0, rsp_drops0, con_drops0;
    logic [6:0] rsp_data0, con_data0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wbu_link_peer #(.LGFIFO(2), .OPT_ROUND_ROBIN(1'b1)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .i_cmd_stb(cmd_stb), .i_cmd_data(cmd_data), .o_cmd_busy(cmd_busy),
        .i_console_stb(con_in_stb), .i_console_data(con_in_data), .o_console_busy(con_in_busy),
        .o_tx_stb(tx_stb), .o_tx_data(tx_data), .i_tx_busy(tx_busy),
        .i_rx_stb(rx_stb), .i_rx_data(rx_data),
        .o_rsp_stb(rsp_stb), .o_rsp_data(rsp_data), .i_rsp_busy(rsp_busy),
        .o_con_stb(con_stb), .o_con_data(con_data), .i_con_busy(con_busy),
        .o_rsp_drops(rsp_drops), .o_con_drops(con_drops)
    );

    wbu_link_peer #(.LGFIFO(4), .OPT_ROUND_ROBIN(1'b0)) dut0 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .i_cmd_stb(cmd_stb), .i_cmd_data(cmd_data), .o_cmd_busy(cmd_busy0),
        .i_console_stb(con_in_stb), .i_console_data(con_in_data), .o_console_busy(con_in_busy0),
        .o_tx_stb(tx_stb0), .o_tx_data(tx_data0), .i_tx_busy(tx_busy),
        .i_rx_stb(rx_stb), .i_rx_data(rx_data),
        .o_rsp_stb(rsp_stb0), .o_rsp_data(rsp_data0), .i_rsp_busy(rsp_busy),
        .o_con_stb(con_stb0), .o_con_data(con_data0), .i_con_busy(con_busy),
        .o_rsp_drops(rsp_drops0), .o_con_drops(con_drops0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmd_stb = 1'b0; cmd_data = 7'd0; con_in_stb = 1'b0; con_in_data = 7'd0;
        tx_busy = 1'b0; rx_stb = 1'b0; rx_data = 8'd0; rsp_busy = 1'b0; con_busy = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_stb  = 1'b1;
        rx_data = b;
        step();
        rx_stb  = 1'b0;
    endtask

    logic [7:0] got_rr [4];
    logic [7:0] got_fx [4];
    int         n_rr, n_fx;

    initial begin
        do_reset();
        check("reset tx_stb", 32'(tx_stb), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'd0);
        check("reset rsp_stb", 32'(rsp_stb), 32'd0);
        check("reset con_stb", 32'(con_stb), 32'd0);
        check("reset rsp_drops", 32'(rsp_drops), 32'd0);

        // Lone command char is tagged and presented for exactly one cycle
        cmd_stb = 1'b1; cmd_data = 7'h41;
        check("t1 cmd_busy", 32'(cmd_busy), 32'd0);
        step();
        cmd_stb = 1'b0;
        check("t1 tx_stb", 32'(tx_stb), 32'd1);
        check("t1 tx_data", 32'(tx_data), 32'hC1);
        step();
        check("t1 tx_stb drop", 32'(tx_stb), 32'd0);

        // Contested arbitration: alternation vs fixed priority
        do_reset();
        n_rr = 0; n_fx = 0;
        for (int i = 0; i < 4; i++) begin
            got_rr[i] = 8'h00;
            got_fx[i] = 8'h00;
        end
        cmd_stb = 1'b1; cmd_data = 7'h10; con_in_stb = 1'b1; con_in_data = 7'h20;
        for (int c = 0; c < 8; c++) begin
            step();
            if (tx_stb && n_rr < 4) begin got_rr[n_rr] = tx_data; n_rr++; end
            if (tx_stb0 && n_fx < 4) begin got_fx[n_fx] = tx_data0; n_fx++; end
            if (!tx_stb0)
                check("t2 fixed console stalled", 32'(con_in_busy0), 32'd1);
        end
        cmd_stb = 1'b0; con_in_stb = 1'b0;
        check("t2 rr byte0", 32'(got_rr[0]), 32'h90);
        check("t2 rr byte1", 32'(got_rr[1]), 32'h20);
        check("t2 rr byte2", 32'(got_rr[2]), 32'h90);
        check("t2 rr byte3", 32'(got_rr[3]), 32'h20);
        for (int i = 0; i < 4; i++)
            check("t2 fixed byte", 32'(got_fx[i]), 32'h90);

        // Back-pressure holds the byte and blocks both sources
        do_reset();
        tx_busy = 1'b1;
        cmd_stb = 1'b1; cmd_data = 7'h41;
        step();
        con_in_stb = 1'b1; con_in_data = 7'h22;
        for (int c = 0; c < 10; c++) begin
            check("t3 tx_stb held", 32'(tx_stb), 32'd1);
            check("t3 tx_data held", 32'(tx_data), 32'hC1);
            check("t3 cmd_busy", 32'(cmd_busy), 32'd1);
            check("t3 console_busy", 32'(con_in_busy), 32'd1);
            step();
        end
        cmd_stb = 1'b0; con_in_stb = 1'b0; tx_busy = 1'b0;

        // Overflow into a 4-deep rsp FIFO, then write-on-full with same-cycle pop
        do_reset();
        rsp_busy = 1'b1;
        for (int i = 1; i <= 6; i++)
            rx_byte(8'h80 + 8'(i));
        check("t4 rsp_drops", 32'(rsp_drops), 32'd2);
        check("t4 deep fifo no drops", 32'(rsp_drops0), 32'd0);
        check("t4 head held", 32'(rsp_data), 32'h01);
        rsp_busy = 1'b0;
        rx_byte(8'h87);
        rsp_busy = 1'b1;
        check("t4 drops after pop+write", 32'(rsp_drops), 32'd2);
        rsp_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [6:0] exp_c;
            exp_c = (i == 3) ? 7'h07 : 7'(i + 2);
            check("t4 rsp_stb", 32'(rsp_stb), 32'd1);
            check("t4 rsp_data", 32'(rsp_data), 32'(exp_c));
            step();
        end
        check("t4 rsp empty", 32'(rsp_stb), 32'd0);

        // Interleaved demux
        do_reset();
        rsp_busy = 1'b1; con_busy = 1'b1;
        rx_byte(8'h85);
        rx_byte(8'h33);
        rx_byte(8'h86);
        check("t5 rsp head", 32'(rsp_data), 32'h05);
        check("t5 con_stb", 32'(con_stb), 32'd1);
        check("t5 con head", 32'(con_data), 32'h33);
        rsp_busy = 1'b0;
        step();
        rsp_busy = 1'b1;
        check("t5 rsp second", 32'(rsp_data), 32'h06);
        check("t5 rsp_drops", 32'(rsp_drops), 32'd0);
        check("t5 con_drops", 32'(con_drops), 32'd0);

        // Async reset with everything loaded
        do_reset();
        rsp_busy = 1'b1; con_busy = 1'b1; tx_busy = 1'b1;
        cmd_stb = 1'b1; cmd_data = 7'h41;
        for (int i = 1; i <= 5; i++)
            rx_byte(8'h80 + 8'(i));
        cmd_stb = 1'b0;
        rx_byte(8'h31);
        check("t6 pre tx_stb", 32'(tx_stb), 32'd1);
        check("t6 pre con_stb", 32'(con_stb), 32'd1);
        check("t6 pre rsp_drops", 32'(rsp_drops), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6 tx_stb", 32'(tx_stb), 32'd0);
        check("t6 tx_data", 32'(tx_data), 32'd0);
        check("t6 rsp_stb", 32'(rsp_stb), 32'd0);
        check("t6 con_stb", 32'(con_stb), 32'd0);
        check("t6 rsp_drops", 32'(rsp_drops), 32'd0);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
